alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU for the datapath; next generation of the single-cycle 3-op ALU.
//  Adds logic, compare and shift ops plus iterative unsigned MUL/DIVU, registered result and flags.
//  Uses a valid/ready handshake on both sides so the control unit can stall on long ops.
//  Sits between the register-file read stage and write-back.
// PARAMETERS
//  WIDTH     32  operand/result width (>=8); also the MUL/DIVU iteration count
//  OPW       4   opcode width
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset: asynchronous assert, active-low
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block can accept a new op
//  op         in   OPW    operation, codes from alu_pkg
//  a, b       in   WIDTH  operands
//  out_valid  out  1      result/flags valid, held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  primary result (MUL low half, DIVU quotient)
//  result_hi  out  WIDTH  MUL high half / DIVU remainder; 0 for other ops
//  zero       out  1      result==0 (result only, not result_hi)
//  carry      out  1      ADD carry-out; SUB borrow (a<b unsigned); 0 otherwise
//  ovf        out  1      signed overflow for ADD/SUB; 0 otherwise
//  dz         out  1      DIVU with b==0
// BEHAVIOUR
//  Ops: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5 (signed, result 0/1), SLTU 6, SLL 7, SRL 8,
//   SRA 9 (shift amount b[$clog2(WIDTH)-1:0]), MUL 10, DIVU 11, PASSB 15; undefined codes act as PASSB.
//  FSM: IDLE -> (accept, 1-cycle op) DONE; IDLE -> (accept, MUL/DIVU, b!=0) CALC; CALC -> DONE
//   after WIDTH iterations; DONE -> (out_ready) IDLE.
//  Accept = in_valid & in_ready; in_ready=1 only in IDLE. Operands/op captured on accept; inputs
//   ignored otherwise.
//  Latency accept->out_valid: 1 cycle for single-cycle ops and DIVU-by-zero; WIDTH+1 for MUL/DIVU.
//  out_valid=1 only in DONE; result/flags stable while out_valid & !out_ready.
//  Transfer completes on out_valid & out_ready; next op accepted earliest the following cycle.
//  Arithmetic: ADD/SUB computed WIDTH+1 wide unsigned for carry; ovf = operand signs equal (ADD) /
//   differ (SUB) and result sign differs from a.
//  MUL: unsigned shift-add, 2*WIDTH product, one bit per cycle, LSB first.
//  DIVU: restoring, one quotient bit per cycle, MSB first. b==0: result all-ones, result_hi=a, dz=1.
//  Reset (any state, incl. mid-CALC): state IDLE, iteration counter 0, result/result_hi 0, all flags 0,
//   out_valid 0, in_ready 1 after release. Aborted op is discarded, no partial output.
//  in_valid while busy: held off by in_ready=0, no loss, no corruption of op in progress.
// STRUCTURE
//  alu_pkg: opcode localparams, FSM state encoding (IDLE/CALC/DONE).
//  Sub-module alu_mc_iter: iterative MUL/DIVU datapath (acc/quotient regs, counter, start/busy/fin);
//   top holds FSM, single-cycle combinational ops, handshake and output registers.
// TESTING
//  ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, ovf=1, carry=0, zero=0, out_valid 1 cycle later.
//  SUB 0x5-0x5 -> 0, zero=1, carry=0; SUB 0x0-0x1 -> 0xFFFFFFFF, carry=1, ovf=0.
//  MUL 0xFFFFFFFF*0x2 -> result 0xFFFFFFFE, result_hi 0x1, out_valid exactly 33 cycles after accept.
//  DIVU 100/7 -> result 14, result_hi 2 after 33 cycles; DIVU 9/0 -> all-ones, result_hi 9, dz=1, 1 cycle.
//  Backpressure: out_ready=0 for 5 cycles -> outputs stable, in_ready=0, new in_valid not accepted.
//  rst_n low at CALC iteration 10 of MUL -> out_valid 0 immediately, all outputs 0, in_ready 1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_PASSB = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath: unsigned shift-add multiply (LSB first) and restoring divide (MSB first).
module alu_mc_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_fin,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_div;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_m;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_sub;

    // o_lo/o_hi are the register values after this cycle's step, so the top can
    // capture the final answer on the same edge as the last iteration.
    always_comb begin
        w_add     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
        w_rem_sub = w_rem_sh - {1'b0, r_m};
        if (r_div) begin
            o_hi = w_rem_sub[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_rem_sub[WIDTH-1:0];
            o_lo = {r_lo[WIDTH-2:0], ~w_rem_sub[WIDTH]};
        end else begin
            {o_hi, o_lo} = {w_add, r_lo[WIDTH-1:1]};
        end
    end

    assign o_fin = r_busy && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_div  <= 1'b0;
            r_lo   <= '0;
            r_hi   <= '0;
            r_m    <= '0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_div  <= i_div;
            r_lo   <= i_a;
            r_hi   <= '0;
            r_m    <= i_b;
        end else if (r_busy) begin
            r_lo  <= o_lo;
            r_hi  <= o_hi;
            r_cnt <= r_cnt + CW'(1);
            if (o_fin) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIVU,
// valid/ready on both sides, registered result and flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             dz
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_long;
    logic             w_start;
    logic             w_fin;
    logic [3:0]       w_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sc_res;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_carry;
    logic             w_sc_ovf;
    logic             w_sc_dz;
    logic [WIDTH-1:0] w_iter_lo;
    logic [WIDTH-1:0] w_iter_hi;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_dz;

    // Codes beyond the 4-bit map fall into PASSB like any other undefined code.
    assign w_op      = (32'(op) > 32'd15) ? OP_PASSB : 4'(op);
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid & in_ready;
    assign w_long    = ((w_op == OP_MUL) || (w_op == OP_DIVU)) && (b != '0);
    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff    = {1'b0, a} - {1'b0, b};
    assign w_shamt   = b[SHW-1:0];

    always_comb begin
        w_sc_res   = '0;
        w_sc_hi    = '0;
        w_sc_carry = 1'b0;
        w_sc_ovf   = 1'b0;
        w_sc_dz    = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_sc_res   = w_sum[WIDTH-1:0];
                w_sc_carry = w_sum[WIDTH];
                w_sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_res   = w_diff[WIDTH-1:0];
                w_sc_carry = w_diff[WIDTH];
                w_sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_sc_res = a & b;
            OP_OR:   w_sc_res = a | b;
            OP_XOR:  w_sc_res = a ^ b;
            OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  w_sc_res = a << w_shamt;
            OP_SRL:  w_sc_res = a >> w_shamt;
            OP_SRA:  w_sc_res = $unsigned($signed(a) >>> w_shamt);
            // MUL reaches here only with b==0: product is zero without iterating.
            OP_MUL: begin
                w_sc_res = '0;
                w_sc_hi  = '0;
            end
            OP_DIVU: begin
                w_sc_res = '1;
                w_sc_hi  = a;
                w_sc_dz  = 1'b1;
            end
            default: w_sc_res = b;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_long) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_CALC;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_CALC: if (w_fin) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
        end else if (w_accept && !w_long) begin
            r_result    <= w_sc_res;
            r_result_hi <= w_sc_hi;
            r_zero      <= (w_sc_res == '0);
            r_carry     <= w_sc_carry;
            r_ovf       <= w_sc_ovf;
            r_dz        <= w_sc_dz;
        end else if ((r_state == ST_CALC) && w_fin) begin
            r_result    <= w_iter_lo;
            r_result_hi <= w_iter_hi;
            r_zero      <= (w_iter_lo == '0);
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
        end
    end

    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign dz        = r_dz;

    alu_mc_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_div   (w_op == OP_DIVU),
        .i_a     (a),
        .i_b     (b),
        .o_fin   (w_fin),
        .o_lo    (w_iter_lo),
        .o_hi    (w_iter_hi)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: hand-computed vectors, latency, backpressure and mid-op reset.
module tb_alu_mc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic        dz;

    int errors = 0;
    int checks = 0;
    int lat;
    int seen;

    alu_mc #(
        .WIDTH(32),
        .OPW  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one op while idle, returns cycles from accept edge until out_valid.
    task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int l);
        @(negedge clk);
        chk("in_ready_before_issue", {63'b0, in_ready}, 64'd1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'd0;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        l = 1;
        while (!out_valid && l < 200) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic check_all(input string tag, input int l, input int el,
                             input logic [31:0] er, input logic [31:0] eh,
                             input logic ez, input logic ec, input logic eo, input logic ed);
        chk({tag, "_latency"}, 64'(l), 64'(el));
        chk({tag, "_out_valid"}, {63'b0, out_valid}, 64'd1);
        chk({tag, "_result"}, {32'b0, result}, {32'b0, er});
        chk({tag, "_result_hi"}, {32'b0, result_hi}, {32'b0, eh});
        chk({tag, "_flags"}, {60'b0, zero, carry, ovf, dz}, {60'b0, ez, ec, eo, ed});
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = 4'd0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_outputs", {result, result_hi}, 64'd0);
        chk("reset_flags", {60'b0, zero, carry, ovf, dz}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);

        run(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, lat);
        check_all("add_ovf", lat, 1, 32'h8000_0000, 32'h0, 0, 0, 1, 0);
        drain();
        run(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        check_all("add_carry", lat, 1, 32'h0, 32'h0, 1, 1, 0, 0);
        drain();
        run(4'd1, 32'h5, 32'h5, lat);
        check_all("sub_eq", lat, 1, 32'h0, 32'h0, 1, 0, 0, 0);
        drain();
        run(4'd1, 32'h0, 32'h1, lat);
        check_all("sub_borrow", lat, 1, 32'hFFFF_FFFF, 32'h0, 0, 1, 0, 0);
        drain();
        run(4'd1, 32'h8000_0000, 32'h1, lat);
        check_all("sub_ovf", lat, 1, 32'h7FFF_FFFF, 32'h0, 0, 0, 1, 0);
        drain();
        run(4'd2, 32'hF0F0_FF00, 32'h0FF0_F0F0, lat);
        check_all("and", lat, 1, 32'h00F0_F000, 32'h0, 0, 0, 0, 0);
        drain();
        run(4'd3, 32'hF0F0_FF00, 32'h0FF0_F0F0, lat);
        check_all("or", lat, 1, 32'hFFF0_FFF0, 32'h0, 0, 0, 0, 0);
        drain();
        run(4'd4, 32'hF0F0_FF00, 32'h0FF0_F0F0, lat);
        check_all("xor", lat, 1, 32'hFF00_0FF0, 32'h0, 0, 0, 0, 0);
        drain();
        run(4'd5, 32'hFFFF_FFFF, 32'h1, lat);
        check_all("slt", lat, 1, 32'h1, 32'h0, 0, 0, 0, 0);
        drain();
        run(4'd6, 32'hFFFF_FFFF, 32'h1, lat);
        check_all("sltu", lat, 1, 32'h0, 32'h0, 1, 0, 0, 0);
        drain();
        run(4'd7, 32'h1, 32'h1F, lat);
        check_all("sll31", lat, 1, 32'h8000_0000, 32'h0, 0, 0, 0, 0);
        drain();
        run(4'd7, 32'h1, 32'h21, lat);
        check_all("sll_wrap", lat, 1, 32'h2, 32'h0, 0, 0, 0, 0);
        drain();
        run(4'd8, 32'h8000_0000, 32'h4, lat);
        check_all("srl", lat, 1, 32'h0800_0000, 32'h0, 0, 0, 0, 0);
        drain();
        run(4'd9, 32'h8000_0000, 32'h4, lat);
        check_all("sra", lat, 1, 32'hF800_0000, 32'h0, 0, 0, 0, 0);
        drain();
        run(4'd15, 32'h1111_1111, 32'h0000_1234, lat);
        check_all("passb", lat, 1, 32'h0000_1234, 32'h0, 0, 0, 0, 0);
        drain();
        run(4'd13, 32'h1111_1111, 32'hCAFE_0000, lat);
        check_all("undef_op", lat, 1, 32'hCAFE_0000, 32'h0, 0, 0, 0, 0);
        drain();

        run(4'd10, 32'hFFFF_FFFF, 32'h2, lat);
        check_all("mul", lat, 33, 32'hFFFF_FFFE, 32'h1, 0, 0, 0, 0);
        drain();
        run(4'd10, 32'h0001_0000, 32'h0001_0000, lat);
        check_all("mul_hi_only", lat, 33, 32'h0, 32'h1, 1, 0, 0, 0);
        drain();
        run(4'd11, 32'd100, 32'd7, lat);
        check_all("divu", lat, 33, 32'd14, 32'd2, 0, 0, 0, 0);
        drain();
        run(4'd11, 32'd9, 32'd0, lat);
        check_all("divu_zero", lat, 1, 32'hFFFF_FFFF, 32'd9, 0, 0, 0, 1);
        drain();

        // Backpressure: result held while the consumer stalls, new op refused.
        out_ready = 1'b0;
        run(4'd0, 32'd3, 32'd4, lat);
        check_all("bp_add", lat, 1, 32'd7, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd1;
        a = 32'd100;
        b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_valid_%0d", i), {63'b0, out_valid}, 64'd1);
            chk($sformatf("bp_hold_result_%0d", i), {32'b0, result}, 64'd7);
            chk($sformatf("bp_in_ready_%0d", i), {63'b0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {63'b0, out_valid}, 64'd1 - 64'd1);
        chk("bp_release_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        chk("bp_no_ghost_op", {63'b0, out_valid}, 64'd0);

        // Asynchronous reset at iteration 10 of a MUL.
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd10;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_busy_before_reset", {63'b0, in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {63'b0, out_valid}, 64'd0);
        chk("abort_outputs", {result, result_hi}, 64'd0);
        chk("abort_flags", {60'b0, zero, carry, ovf, dz}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("abort_no_output", 64'(seen), 64'd0);
        run(4'd0, 32'd2, 32'd3, lat);
        check_all("post_abort_add", lat, 1, 32'd5, 32'h0, 0, 0, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
